mul_mux_unit: RTL and testbench

MUL_MUX_UNIT -- requirements
Module: mul_mux_unit

---
 rtl/mul_mux_unit_if.sv | 32 +++
 rtl/mul_mux_unit.sv | 57 +++++
 tb/tb_mul_mux_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mul_mux_unit_if.sv
// Operand/result bundle for mul_mux_unit: select-sum, gate and signed multiplier signals.
interface mul_mux_unit_if;
   localparam int unsigned DW = 8;
   localparam int unsigned PW = 16;

   logic [DW-1:0] A;
   logic [DW-1:0] B;
   logic [DW-1:0] C;
   logic          SA;
   logic          SB;
   logic          SC;
   logic [DW-1:0] GIn;
   logic          En;
   logic [DW-1:0] MA;
   logic [DW-1:0] MB;
   logic          WE;
   logic [DW-1:0] SumOut;
   logic [DW-1:0] GateOut;
   logic [DW-1:0] MulOut;
   logic [PW-1:0] ProdReg;
   logic          ProdValid;

   modport master (
      output A, B, C, SA, SB, SC, GIn, En, MA, MB, WE,
      input  SumOut, GateOut, MulOut, ProdReg, ProdValid
   );

   modport slave (
      input  A, B, C, SA, SB, SC, GIn, En, MA, MB, WE,
      output SumOut, GateOut, MulOut, ProdReg, ProdValid
   );
endinterface

// File: rtl/mul_mux_unit.sv
// Select-sum, data gate and signed 8x8 multiplier with a registered full product.
// Define MUL_MUX_UNIT_SAT_EN to make MulOut saturate to [-128,127] instead of truncating.
module mul_mux_unit (
   input logic           Clock,
   input logic           nReset,
   mul_mux_unit_if.slave bus
);
   localparam int unsigned DW = 8;
   localparam int unsigned PW = 16;

   logic        [DW-1:0] sum;
   logic        [DW-1:0] mul_out;
   logic signed [PW-1:0] prod;
   logic        [PW-1:0] prod_q;
   logic                 prod_valid_q;

   // Additive select: every enabled operand contributes, wrapping mod 256
   always_comb begin
      sum = '0;
      if (bus.SA) sum = sum + bus.A;
      if (bus.SB) sum = sum + bus.B;
      if (bus.SC) sum = sum + bus.C;
   end

   assign prod = PW'($signed(bus.MA)) * PW'($signed(bus.MB));

`ifdef MUL_MUX_UNIT_SAT_EN
   always_comb begin
      mul_out = prod[DW-1:0];
      if (prod > 16'sd127)
         mul_out = 8'h7F;
      else if (prod < -16'sd128)
         mul_out = 8'h80;
   end
`else
   always_comb begin
      mul_out = prod[DW-1:0];
   end
`endif

   // Product register; reset clears it regardless of WE
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         prod_q       <= '0;
         prod_valid_q <= 1'b0;
      end else if (bus.WE) begin
         prod_q       <= PW'(prod);
         prod_valid_q <= 1'b1;
      end
   end

   assign bus.SumOut    = sum;
   assign bus.GateOut   = bus.En ? bus.GIn : '0;
   assign bus.MulOut    = mul_out;
   assign bus.ProdReg   = prod_q;
   assign bus.ProdValid = prod_valid_q;
endmodule

// File: tb/tb_mul_mux_unit.sv
// Self-checking bench for mul_mux_unit: directed corner cases plus randomized traffic
// compared against an integer-arithmetic reference model.
module tb_mul_mux_unit;
   logic Clock;
   logic nReset;
   int   tests;
   int   fails;
   int   exp_prod;
   bit   exp_valid;

   mul_mux_unit_if bus ();

   mul_mux_unit dut (
      .Clock  (Clock),
      .nReset (nReset),
      .bus    (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic logic [7:0] ref_sum(logic [7:0] a, logic [7:0] b, logic [7:0] c,
                                          logic sa, logic sb, logic sc);
      int s;
      s = int'(a) * int'(sa) + int'(b) * int'(sb) + int'(c) * int'(sc);
      return 8'(s % 256);
   endfunction

   function automatic int ref_prod(logic [7:0] ma, logic [7:0] mb);
      return int'($signed(ma)) * int'($signed(mb));
   endfunction

   function automatic logic [7:0] ref_mul(logic [7:0] ma, logic [7:0] mb);
      int p;
      p = ref_prod(ma, mb);
`ifdef MUL_MUX_UNIT_SAT_EN
      if (p > 127) return 8'h7F;
      if (p < -128) return 8'h80;
`endif
      return 8'(p);
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_comb(input string tag);
      check({tag, "_sum"},  16'(bus.SumOut),
            16'(ref_sum(bus.A, bus.B, bus.C, bus.SA, bus.SB, bus.SC)));
      check({tag, "_gate"}, 16'(bus.GateOut), bus.En ? 16'(bus.GIn) : 16'h0000);
      check({tag, "_mul"},  16'(bus.MulOut), 16'(ref_mul(bus.MA, bus.MB)));
   endtask

   task automatic check_regs(input string tag);
      check({tag, "_prod"},  bus.ProdReg, 16'(exp_prod));
      check({tag, "_valid"}, 16'(bus.ProdValid), 16'(exp_valid));
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      exp_prod  = 0;
      exp_valid = 1'b0;
      nReset    = 1'b0;
      bus.A = '0; bus.B = '0; bus.C = '0;
      bus.SA = 1'b0; bus.SB = 1'b0; bus.SC = 1'b0;
      bus.GIn = '0; bus.En = 1'b0;
      bus.MA = '0; bus.MB = '0; bus.WE = 1'b1;

      // Reset state before any clock edge, and WE ignored while in reset
      #1;
      check_regs("reset");
      @(posedge Clock); #1;
      check_regs("reset_we_ignored");
      @(negedge Clock);
      nReset = 1'b1;
      bus.WE = 1'b0;

      // Select-sum wrap and all-clear
      bus.A = 8'h05; bus.B = 8'h10; bus.C = 8'hFF;
      bus.SA = 1'b1; bus.SB = 1'b0; bus.SC = 1'b1;
      #1;
      check("sum_wrap", 16'(bus.SumOut), 16'h0004);
      bus.SA = 1'b0; bus.SC = 1'b0;
      #1;
      check("sum_none", 16'(bus.SumOut), 16'h0000);
      bus.SA = 1'b1; bus.SB = 1'b1; bus.SC = 1'b1;
      #1;
      check("sum_all", 16'(bus.SumOut), 16'h0014);

      // Gate
      bus.GIn = 8'hA5; bus.En = 1'b1;
      #1;
      check("gate_on", 16'(bus.GateOut), 16'h00A5);
      bus.En = 1'b0;
      #1;
      check("gate_off", 16'(bus.GateOut), 16'h0000);

      // Multiplier: overflow case and negative in-range case
      bus.MA = 8'h0C; bus.MB = 8'h0D;
      #1;
`ifdef MUL_MUX_UNIT_SAT_EN
      check("mul_ovf", 16'(bus.MulOut), 16'h007F);
`else
      check("mul_ovf", 16'(bus.MulOut), 16'h009C);
`endif
      bus.MA = 8'hFE; bus.MB = 8'h03;
      #1;
      check("mul_neg", 16'(bus.MulOut), 16'h00FA);

      // Load -128*-128, then hold with WE=0 and new operands
      @(negedge Clock);
      bus.MA = 8'h80; bus.MB = 8'h80; bus.WE = 1'b1;
      @(posedge Clock); #1;
      check("load_max", bus.ProdReg, 16'h4000);
      check("load_valid", 16'(bus.ProdValid), 16'h0001);
      @(negedge Clock);
      bus.WE = 1'b0; bus.MA = 8'h12; bus.MB = 8'h34;
      @(posedge Clock); #1;
      check("hold", bus.ProdReg, 16'h4000);
      check("hold_valid", 16'(bus.ProdValid), 16'h0001);

      // Asynchronous reset pulse between edges clears immediately
      @(negedge Clock);
      #1 nReset = 1'b0;
      #1;
      check("async_rst_prod", bus.ProdReg, 16'h0000);
      check("async_rst_valid", 16'(bus.ProdValid), 16'h0000);
      nReset = 1'b1;

      // Reload, then hold reset low with WE=1 across edges
      @(negedge Clock);
      bus.MA = 8'h7F; bus.MB = 8'h80; bus.WE = 1'b1;
      @(posedge Clock); #1;
      check("load_min", bus.ProdReg, 16'hC080);
      nReset = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      check("rst_hold_prod", bus.ProdReg, 16'h0000);
      check("rst_hold_valid", 16'(bus.ProdValid), 16'h0000);
      check_comb("comb_in_reset");
      @(negedge Clock);
      nReset = 1'b1;
      bus.WE = 1'b0;

      // Randomized traffic against the reference model
      exp_prod  = 0;
      exp_valid = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge Clock);
         bus.A = 8'($urandom); bus.B = 8'($urandom); bus.C = 8'($urandom);
         bus.SA = 1'($urandom); bus.SB = 1'($urandom); bus.SC = 1'($urandom);
         bus.GIn = 8'($urandom); bus.En = 1'($urandom);
         bus.MA = 8'($urandom); bus.MB = 8'($urandom);
         bus.WE = ($urandom_range(0, 3) != 0);
         #1;
         check_comb("rand_comb");
         if ($urandom_range(0, 19) == 0) begin
            nReset = 1'b0;
            #1;
            exp_prod  = 0;
            exp_valid = 1'b0;
            check_regs("rand_rst");
            nReset = 1'b1;
         end
         @(posedge Clock);
         if (bus.WE) begin
            exp_prod  = ref_prod(bus.MA, bus.MB);
            exp_valid = 1'b1;
         end
         #1;
         check_regs("rand_reg");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
